// File: rtl/pov_pkg.sv
// rtl/pov_pkg.sv - shared constants, state encoding and pixel helpers for the POV pixel scheduler
//
// Contents:
//   PIX_W              GRB pixel width (24)
//   MODE_*             mode encoding: texture, framebuffer, gradient, blank
//   pov_state_t        scheduler FSM states
//   grad_pixel()       angular colour wheel pixel for an 8-bit column code
//   scale_pixel()      per-channel brightness scaling (used when POV_BRIGHTNESS_EN is defined)
package pov_pkg;

    localparam int PIX_W = 24;

    localparam logic [1:0] MODE_TEX   = 2'd0;
    localparam logic [1:0] MODE_FB    = 2'd1;
    localparam logic [1:0] MODE_GRAD  = 2'd2;
    localparam logic [1:0] MODE_BLANK = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } pov_state_t;

    // Red fades into green over the first half turn, green into blue over the second.
    function automatic logic [PIX_W-1:0] grad_pixel(input logic [7:0] c);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        if (c < 8'd128) begin
            r = 8'd255 - c;
            g = c;
            b = 8'd0;
        end else begin
            r = 8'd0;
            g = 8'd255 - (c - 8'd128);
            b = c - 8'd128;
        end
        return {g, r, b};
    endfunction

    // (chan * (level + 1)) >> 8 per channel; level 255 is an exact pass-through.
    function automatic logic [PIX_W-1:0] scale_pixel(input logic [PIX_W-1:0] px,
                                                     input logic [7:0]       level);
        logic [PIX_W-1:0] res;
        for (int i = 0; i < 3; i++) begin
            res[i*8 +: 8] = 8'((16'(px[i*8 +: 8]) * (16'(level) + 16'd1)) >> 8);
        end
        return res;
    endfunction

endpackage

// File: rtl/pov_skid_fifo.sv
// rtl/pov_skid_fifo.sv - synchronous FIFO with occupancy count for the pixel output buffer
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   wr_en/wr_data  push side (ignored when full)
//   rd_en          pop the head entry (ignored when empty)
//   rd_data        head entry, valid while count != 0
//   count          number of stored entries (0..DEPTH)
module pov_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && (count != CNT_W'(DEPTH));
    assign do_rd   = rd_en && (count != '0);
    assign rd_data = store[rd_ptr];

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                store[wr_ptr] <= wr_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pov_pixel_scheduler.sv
// rtl/pov_pixel_scheduler.sv - per-refresh column latch, pipelined row reads and pixel stream to the strip controller
//
// Optional feature macro: POV_BRIGHTNESS_EN (adds brightness[7:0] and one scaling stage).
//
// Ports:
//   clk, reset_n                clock, asynchronous active-low reset
//   theta                       current angle index
//   mode_req                    requested source mode (applied only at a revolution wrap)
//   frame_start                 strip controller refresh pulse
//   brightness                  global scale, only with POV_BRIGHTNESS_EN
//   mem_rd_en, mem_addr         read request to texture ROM and framebuffer
//   mem_rdata_tex, mem_rdata_fb read data, MEM_LAT cycles after mem_rd_en
//   px_valid/px_ready           output handshake
//   px_data, px_index, px_last  GRB pixel, its row, last-row marker
//   mode_active                 mode applied to the current/last frame
//   busy                        refresh in progress
module pov_pixel_scheduler
    import pov_pkg::*;
#(
    parameter int LED_COUNT  = 52,
    parameter int TEX_WIDTH  = 256,
    parameter int THETA_BITS = 6,
    parameter int MEM_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PX_BITS    = 6
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [THETA_BITS-1:0]                  theta,
    input  logic [1:0]                             mode_req,
    input  logic                                   frame_start,
`ifdef POV_BRIGHTNESS_EN
    input  logic [7:0]                             brightness,
`endif
    output logic                                   mem_rd_en,
    output logic [$clog2(LED_COUNT*TEX_WIDTH)-1:0] mem_addr,
    input  logic [23:0]                            mem_rdata_tex,
    input  logic [23:0]                            mem_rdata_fb,
    output logic                                   px_valid,
    input  logic                                   px_ready,
    output logic [23:0]                            px_data,
    output logic [PX_BITS-1:0]                     px_index,
    output logic                                   px_last,
    output logic [1:0]                             mode_active,
    output logic                                   busy
);

    localparam int ADDR_W = $clog2(LED_COUNT * TEX_WIDTH);
    localparam int COL_W  = $clog2(TEX_WIDTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W  = PIX_W + PX_BITS + 1;
    localparam logic [PX_BITS-1:0] LAST_ROW = PX_BITS'(LED_COUNT - 1);

    pov_state_t          state;
    logic [PX_BITS-1:0]  row;
    logic [COL_W-1:0]    col;
    logic [COL_W-1:0]    theta_col;
    logic [7:0]          col_code;
    logic [THETA_BITS-1:0] prev_theta;
    logic                first_frame;

    logic                issue;
    logic                credit_ok;
    logic [CNT_W-1:0]    outstanding;
    logic [CNT_W-1:0]    fifo_count;

    logic                tag_vld [MEM_LAT];
    logic [PX_BITS-1:0]  tag_row [MEM_LAT];
    logic [PIX_W-1:0]    sel_px;

    logic                wr_en;
    logic [PIX_W-1:0]    wr_px;
    logic [PX_BITS-1:0]  wr_row;
    logic [ENT_W-1:0]    fifo_rd_data;

`ifdef POV_BRIGHTNESS_EN
    logic [7:0]          br_level;
    logic                br_vld;
    logic [PIX_W-1:0]    br_px;
    logic [PX_BITS-1:0]  br_row;
`endif

    // col = (theta * TEX_WIDTH) >> THETA_BITS, written as a bit-placement.
    generate
        if (COL_W > THETA_BITS) begin : g_col_pad
            assign theta_col = {theta, {(COL_W-THETA_BITS){1'b0}}};
        end else if (COL_W == THETA_BITS) begin : g_col_eq
            assign theta_col = theta;
        end else begin : g_col_trunc
            assign theta_col = theta[THETA_BITS-1 -: COL_W];
        end

        // Gradient works on an 8-bit column code: column left-aligned into 8 bits.
        if (COL_W >= 8) begin : g_code_trunc
            assign col_code = col[COL_W-1 -: 8];
        end else begin : g_code_pad
            assign col_code = {col, {(8-COL_W){1'b0}}};
        end
    endgenerate

    // Counting in-flight reads against FIFO space keeps the buffer from
    // overflowing no matter how long px_ready stays low.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
    assign issue     = (state == ST_ISSUE) && credit_ok;

    // Issue is combinational so the first read goes out in the cycle after LATCH.
    assign mem_rd_en = issue && ((mode_active == MODE_TEX) || (mode_active == MODE_FB));
    assign mem_addr  = mem_rd_en ? ADDR_W'({row, col}) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            row         <= '0;
            col         <= '0;
            prev_theta  <= '0;
            first_frame <= 1'b1;
            mode_active <= MODE_BLANK;
            busy        <= 1'b0;
`ifdef POV_BRIGHTNESS_EN
            br_level    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    col         <= theta_col;
                    prev_theta  <= theta;
                    first_frame <= 1'b0;
                    // Mode switches only when theta wraps, so a frame never mixes sources.
                    if (first_frame || (theta < prev_theta)) begin
                        mode_active <= mode_req;
                    end
`ifdef POV_BRIGHTNESS_EN
                    br_level    <= brightness;
`endif
                    row   <= '0;
                    busy  <= 1'b1;
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (issue) begin
                        if (row == LAST_ROW) begin
                            state <= ST_DRAIN;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((outstanding == '0) && (fifo_count == '0)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tag pipeline mirrors memory latency for every mode, including the
    // synthesised ones, so ordering and timing never depend on mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_vld[i] <= 1'b0;
                tag_row[i] <= '0;
            end
        end else begin
            tag_vld[0] <= issue;
            tag_row[0] <= row;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_row[i] <= tag_row[i-1];
            end
        end
    end

    always_comb begin
        sel_px = '0;
        case (mode_active)
            MODE_TEX:  sel_px = mem_rdata_tex;
            MODE_FB:   sel_px = mem_rdata_fb;
            MODE_GRAD: sel_px = grad_pixel(col_code);
            default:   sel_px = '0;
        endcase
    end

`ifdef POV_BRIGHTNESS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_vld <= 1'b0;
            br_px  <= '0;
            br_row <= '0;
        end else begin
            br_vld <= tag_vld[MEM_LAT-1];
            br_px  <= scale_pixel(sel_px, br_level);
            br_row <= tag_row[MEM_LAT-1];
        end
    end

    assign wr_en  = br_vld;
    assign wr_px  = br_px;
    assign wr_row = br_row;
`else
    assign wr_en  = tag_vld[MEM_LAT-1];
    assign wr_px  = sel_px;
    assign wr_row = tag_row[MEM_LAT-1];
`endif

    // A read stays outstanding until its pixel lands in the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else if (issue && !wr_en) begin
            outstanding <= outstanding + 1'b1;
        end else if (!issue && wr_en) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    pov_skid_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data ({wr_px, wr_row, (wr_row == LAST_ROW)}),
        .rd_en   (px_valid && px_ready),
        .rd_data (fifo_rd_data),
        .count   (fifo_count)
    );

    assign px_valid = (fifo_count != '0);
    assign {px_data, px_index, px_last} = fifo_rd_data;

endmodule

// File: tb/tb_pov_pixel_scheduler.sv
// tb/tb_pov_pixel_scheduler.sv - self-checking bench for pov_pixel_scheduler with a frame-level reference model
module tb_pov_pixel_scheduler;

    localparam int LED_COUNT  = 52;
    localparam int TEX_WIDTH  = 256;
    localparam int THETA_BITS = 6;
    localparam int MEM_LAT    = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int PX_BITS    = 6;
    localparam int ADDR_W     = $clog2(LED_COUNT * TEX_WIDTH);

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [THETA_BITS-1:0] theta = '0;
    logic [1:0]            mode_req = 2'd0;
    logic                  frame_start = 1'b0;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [23:0]           mem_rdata_tex;
    logic [23:0]           mem_rdata_fb;
    logic                  px_valid;
    logic                  px_ready = 1'b1;
    logic [23:0]           px_data;
    logic [PX_BITS-1:0]    px_index;
    logic                  px_last;
    logic [1:0]            mode_active;
    logic                  busy;

    always #5 clk = ~clk;

    pov_pixel_scheduler #(
        .LED_COUNT  (LED_COUNT),
        .TEX_WIDTH  (TEX_WIDTH),
        .THETA_BITS (THETA_BITS),
        .MEM_LAT    (MEM_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PX_BITS    (PX_BITS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .theta         (theta),
        .mode_req      (mode_req),
        .frame_start   (frame_start),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata_tex (mem_rdata_tex),
        .mem_rdata_fb  (mem_rdata_fb),
        .px_valid      (px_valid),
        .px_ready      (px_ready),
        .px_data       (px_data),
        .px_index      (px_index),
        .px_last       (px_last),
        .mode_active   (mode_active),
        .busy          (busy)
    );

    function automatic logic [23:0] tex_fn(input int a);
        logic [31:0] h;
        h = 32'(a) * 32'h9E3779B1;
        return h[31:8];
    endfunction

    function automatic logic [23:0] fb_fn(input int a);
        return 24'(a * 7 + 1265808);
    endfunction

    function automatic logic [23:0] grad_ref(input int c);
        int r, g, b;
        if (c < 128) begin
            r = 255 - c; g = c; b = 0;
        end else begin
            r = 0; g = 255 - (c - 128); b = c - 128;
        end
        return {8'(g), 8'(r), 8'(b)};
    endfunction

    // Single-cycle-latency memories.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata_tex <= tex_fn(int'(mem_addr));
            mem_rdata_fb  <= fb_fn(int'(mem_addr));
        end
    end

    int tests = 0;
    int fails = 0;

    logic [30:0]       rx_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    bit                hold = 1'b0;
    logic [30:0]       hold_val;

    int m_prev  = 0;
    bit m_first = 1'b1;
    int m_mode  = 3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (!reset_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_stable", {px_valid, px_data, px_index, px_last}, {1'b1, hold_val});
            end
            hold     = px_valid && !px_ready;
            hold_val = {px_data, px_index, px_last};
            if (px_valid && px_ready) rx_q.push_back({px_data, px_index, px_last});
            if (mem_rd_en) addr_q.push_back(mem_addr);
        end
    endtask

    // Observe at the falling edge, then return 2 time units after the rising edge.
    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        m_first = 1'b1;
        m_prev  = 0;
        m_mode  = 3;
        rx_q.delete();
        addr_q.delete();
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        frame_start = 1'b0;
        px_ready    = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic run_frame(input int th, input int md, input int md_mid,
                             input bit rnd_ready, input int stall_at, input int restart_at);
        int col, k, first_k, stall_cnt, idle_bad;
        bit restarted, timeout;
        logic [23:0] px;
        if (m_first || th < m_prev) m_mode = md;
        m_first = 1'b0;
        m_prev  = th;
        col = (th * TEX_WIDTH) >> THETA_BITS;
        rx_q.delete();
        addr_q.delete();
        theta = THETA_BITS'(th);
        mode_req = 2'(md);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        k = 0; first_k = -1; stall_cnt = 0; restarted = 1'b0; timeout = 1'b1;
        while (k < 3000) begin
            step();
            k++;
            if (first_k < 0 && px_valid) first_k = k;
            theta = THETA_BITS'($urandom);
            mode_req = 2'(md_mid);
            frame_start = 1'b0;
            if (restart_at >= 0 && !restarted && rx_q.size() >= restart_at) begin
                frame_start = 1'b1;
                restarted = 1'b1;
            end
            if (stall_at >= 0 && rx_q.size() >= stall_at && stall_cnt < 20) begin
                px_ready = 1'b0;
                stall_cnt++;
            end else begin
                px_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (k > 2 && !busy && !px_valid) begin
                timeout = 1'b0;
                break;
            end
        end
        chk("frame_timeout", timeout, 0);
        chk("first_px_latency", first_k, MEM_LAT + 2);
        chk("px_count", rx_q.size(), LED_COUNT);
        chk("mode_active", mode_active, m_mode);
        for (int i = 0; i < LED_COUNT && i < rx_q.size(); i++) begin
            case (m_mode)
                0:       px = tex_fn(i * TEX_WIDTH + col);
                1:       px = fb_fn(i * TEX_WIDTH + col);
                2:       px = grad_ref(col);
                default: px = 24'd0;
            endcase
            chk($sformatf("pixel_%0d", i), rx_q[i], {px, PX_BITS'(i), (i == LED_COUNT - 1)});
        end
        if (m_mode < 2) begin
            chk("addr_count", addr_q.size(), LED_COUNT);
            for (int i = 0; i < LED_COUNT && i < addr_q.size(); i++) begin
                chk($sformatf("addr_%0d", i), addr_q[i], i * TEX_WIDTH + col);
            end
        end else begin
            chk("no_mem_reads", addr_q.size(), 0);
        end
        px_ready = 1'b1;
        idle_bad = 0;
        repeat (6) begin
            step();
            if (px_valid || busy) idle_bad++;
        end
        chk("idle_after_frame", idle_bad, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bad;
        logic [30:0] ent;

        // Reset state
        step();
        step();
        chk("rst_px_valid", px_valid, 0);
        chk("rst_px_data", px_data, 0);
        chk("rst_px_index", px_index, 0);
        chk("rst_px_last", px_last, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mode_active", mode_active, 3);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        model_reset();

        // Texture, theta 16, no backpressure
        run_frame(16, 0, 0, 1'b0, -1, -1);
        // 20-cycle stall mid-frame with random ready otherwise
        run_frame(16, 0, 0, 1'b1, 10, -1);

        // Revolution-aligned mode switch
        do_reset();
        run_frame(40, 2, 1, 1'b0, -1, -1);
        chk("mode_first_40", mode_active, 2);
        run_frame(41, 1, 1, 1'b0, -1, -1);
        chk("mode_hold_41", mode_active, 2);
        run_frame(0, 1, 1, 1'b1, -1, -1);
        chk("mode_wrap_0", mode_active, 1);

        // Gradient columns 192 and 0
        do_reset();
        run_frame(48, 2, 3, 1'b0, -1, -1);
        ent = (rx_q.size() > 0) ? rx_q[0] : 31'h0;
        chk("grad_col192", ent[30:7], 24'hBF0040);
        run_frame(0, 2, 0, 1'b0, -1, -1);
        ent = (rx_q.size() > 5) ? rx_q[5] : 31'h0;
        chk("grad_col0", ent[30:7], 24'h00FF00);

        // Asynchronous reset at row 20
        do_reset();
        theta = 6'd16;
        mode_req = 2'd0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        k = 0;
        while (rx_q.size() < 20 && k < 500) begin
            step();
            k++;
        end
        chk("reached_row20", rx_q.size() >= 20, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_px_valid", px_valid, 0);
        chk("arst_px_data", px_data, 0);
        chk("arst_px_index", px_index, 0);
        chk("arst_px_last", px_last, 0);
        chk("arst_mem_rd_en", mem_rd_en, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_mode_active", mode_active, 3);
        step();
        reset_n = 1'b1;
        model_reset();
        bad = 0;
        repeat (30) begin
            step();
            if (px_valid || busy) bad++;
        end
        chk("no_valid_after_reset", bad, 0);
        run_frame(16, 0, 0, 1'b0, -1, -1);

        // frame_start while busy is ignored
        run_frame(24, 3, 2, 1'b0, -1, 10);

        // Randomised frames
        for (int f = 0; f < 8; f++) begin
            run_frame($urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'b1, -1, ($urandom_range(0, 1) != 0) ? 15 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
